// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the FP result collector slice.
//   DATA_WIDTH       width of one IEEE-754 single-precision result word
//   DEPTH_DEFAULT    default number of results collected per run
//   TIMEOUT_DEFAULT  default idle-cycle limit that aborts a run
//   state_e          collector FSM state encoding
package fp_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int DEPTH_DEFAULT   = 18;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/fp_result_collector_if.sv
// fp_result_collector_if: bus between a result producer/reader and the
// collector.
//   start     run start pulse                  (master -> slave)
//   valid_in  result strobe                    (master -> slave)
//   data_in   result word                      (master -> slave)
//   rd_en     readback request                 (master -> slave)
//   rd_addr   readback index                   (master -> slave)
//   rd_data   registered readback word         (slave -> master)
//   rd_valid  readback word valid              (slave -> master)
//   count     results stored in this run       (slave -> master)
//   busy      collecting                       (slave -> master)
//   done      run finished                     (slave -> master)
//   timeout   sticky, run ended by idle limit  (slave -> master)
//   overflow  sticky, result seen after done   (slave -> master)
interface fp_result_collector_if #(
  parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
  parameter int DEPTH      = fp_pkg::DEPTH_DEFAULT
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic                  start;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_W:0]       count;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic                  overflow;

  modport master (
    output start, valid_in, data_in, rd_en, rd_addr,
    input  rd_data, rd_valid, count, busy, done, timeout, overflow
  );

  modport slave (
    input  start, valid_in, data_in, rd_en, rd_addr,
    output rd_data, rd_valid, count, busy, done, timeout, overflow
  );

endinterface

// File: rtl/fp_result_ram.sv
// fp_result_ram: DEPTH x DATA_WIDTH simple dual-port storage with a
// registered synchronous read port.
//   clk     rising-edge clock
//   resetn  synchronous active-low reset (read register only)
//   we      write enable
//   waddr   write index, always < DEPTH when we=1
//   wdata   write word
//   re      read enable; rdata holds while re=0
//   raddr   read index; indices >= DEPTH read as zero
//   rdata   registered read word
// A read and write of the same entry in one cycle returns the old word.
module fp_result_ram #(
  parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
  parameter int DEPTH      = fp_pkg::DEPTH_DEFAULT,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  raddr_ok;

  assign raddr_ok = ({1'b0, raddr} < DEPTH_LIM);
  assign rdata    = rdata_r;

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: loads only on re, out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_r <= '0;
    end else if (re) begin
      if (raddr_ok) begin
        rdata_r <= mem[raddr];
      end else begin
        rdata_r <= '0;
      end
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: captures DEPTH result words from an FP unit into
// local storage, ends a run on a full buffer or on an idle timeout, and
// offers registered readback in every state.
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     fp_result_collector_if slave modport (start, valid_in, data_in,
//           rd_en, rd_addr in; rd_data, rd_valid, count, busy, done,
//           timeout, overflow out)
// The producer is never stalled; there is no ready signal.
module fp_result_collector #(
  parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
  parameter int DEPTH      = fp_pkg::DEPTH_DEFAULT,
  parameter int TIMEOUT    = fp_pkg::TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  fp_result_collector_if.slave bus
);

  import fp_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  // One extra value of headroom so the increment on the timeout cycle
  // cannot wrap.
  localparam int GAP_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);

  state_e                state_r;
  state_e                state_nx;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nx;
  logic [GAP_W-1:0]      gap_r;
  logic [GAP_W-1:0]      gap_nx;
  logic                  timeout_r;
  logic                  timeout_nx;
  logic                  overflow_r;
  logic                  overflow_nx;
  logic                  busy_r;
  logic                  done_r;
  logic                  rd_valid_r;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Next-state and datapath decisions; start overrides every state and
  // drops any result arriving in the same cycle.
  always_comb begin
    state_nx    = state_r;
    count_nx    = count_r;
    gap_nx      = gap_r;
    timeout_nx  = timeout_r;
    overflow_nx = overflow_r;
    wr_en       = 1'b0;

    if (bus.start) begin
      state_nx    = ST_COLLECT;
      count_nx    = '0;
      gap_nx      = '0;
      timeout_nx  = 1'b0;
      overflow_nx = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_COLLECT: begin
          if (bus.valid_in) begin
            // A storing cycle never times out, so the full-buffer exit
            // always wins a tie with the idle limit.
            wr_en    = 1'b1;
            count_nx = count_r + CNT_W'(1);
            gap_nx   = '0;
            if (count_r == LAST_IDX) begin
              state_nx = ST_DONE;
            end else begin
              state_nx = ST_COLLECT;
            end
          end else if (gap_r == GAP_LIMIT) begin
            state_nx   = ST_DONE;
            timeout_nx = 1'b1;
            gap_nx     = gap_r + GAP_W'(1);
          end else begin
            state_nx = ST_COLLECT;
            gap_nx   = gap_r + GAP_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.valid_in) begin
            overflow_nx = 1'b1;
          end else begin
            overflow_nx = overflow_r;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, sticky flags and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      gap_r      <= '0;
      timeout_r  <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nx;
      count_r    <= count_nx;
      gap_r      <= gap_nx;
      timeout_r  <= timeout_nx;
      overflow_r <= overflow_nx;
      busy_r     <= (state_nx == ST_COLLECT);
      done_r     <= (state_nx == ST_DONE);
      rd_valid_r <= bus.rd_en;
    end
  end

  // Writes are gated by reset so an abandoned run stores nothing more.
  fp_result_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_en & resetn),
    .waddr  (count_r[ADDR_W-1:0]),
    .wdata  (bus.data_in),
    .re     (bus.rd_en),
    .raddr  (bus.rd_addr),
    .rdata  (ram_rdata)
  );

  assign bus.rd_data  = ram_rdata;
  assign bus.rd_valid = rd_valid_r;
  assign bus.count    = count_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.timeout  = timeout_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_fp_result_collector.sv
// tb_fp_result_collector: directed scenarios for fp_result_collector with
// a scoreboard. Stimulus pushes expected readback words and expected
// status snapshots into queues; the monitor compares on the falling edge.
module tb_fp_result_collector;

  localparam int DW      = 32;
  localparam int DEPTH   = 18;
  localparam int TIMEOUT = 64;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  fp_result_collector_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fp_result_collector #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] rq [$];
  string       sq_name [$];
  logic [42:0] sq_val [$];
  logic [31:0] last_rd = 32'h0;
  bit          end_req = 1'b0;
  bit          end_ack = 1'b0;

  // Monitor: compares readback words and queued status snapshots.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [42:0] a;
    logic [42:0] ev;
    string       n;
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h with no read pending", bus.rd_data);
      end else begin
        e = rq.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL readback: got %h expected %h", bus.rd_data, e);
        end
      end
    end
    while (sq_name.size() != 0) begin
      n  = sq_name.pop_front();
      ev = sq_val.pop_front();
      a  = {bus.count, bus.busy, bus.done, bus.timeout, bus.overflow,
            bus.rd_valid, bus.rd_data};
      checks++;
      if (a !== ev) begin
        errors++;
        $display("FAIL %s: got cnt=%0d busy=%b done=%b to=%b ov=%b rdv=%b rd=%h expected cnt=%0d busy=%b done=%b to=%b ov=%b rdv=%b rd=%h",
                 n, a[42:37], a[36], a[35], a[34], a[33], a[32], a[31:0],
                 ev[42:37], ev[36], ev[35], ev[34], ev[33], ev[32], ev[31:0]);
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (rq.size() != 0) begin
        errors++;
        $display("FAIL rd_missing: %0d expected reads never returned", rq.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stat(input string n, input int c, input logic b,
                           input logic d, input logic t, input logic o);
    sq_name.push_back(n);
    sq_val.push_back({6'(c), b, d, t, o, 1'b0, last_rd});
  endtask

  task automatic word(input logic [31:0] d);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    rq.push_back(e);
    last_rd = e;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 32'h0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = 5'd0;

    // Reset state
    repeat (3) tick();
    push_stat("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick();

    // Results before any start are ignored
    word(32'h1234_5678);
    push_stat("idle_ignore", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full back-to-back run
    pulse_start();
    push_stat("s1_start", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      word(32'h3F80_0000 + 32'(i));
      push_stat($sformatf("s1_word%0d", i), i + 1, (i < DEPTH - 1),
                (i == DEPTH - 1), 1'b0, 1'b0);
    end
    rd(5'd18, 32'h0);
    rd(5'd31, 32'h0);
    rd(5'd0,  32'h3F80_0000);
    rd(5'd17, 32'h3F80_0011);
    rd(5'd5,  32'h3F80_0005);
    tick();
    tick();
    push_stat("s1_rd_hold", 18, 1'b0, 1'b1, 1'b0, 1'b0);

    // Extra results after done
    word(32'hDEAD_BEEF);
    word(32'hDEAD_BEEF);
    push_stat("s4_overflow", 18, 1'b0, 1'b1, 1'b0, 1'b1);
    rd(5'd17, 32'h3F80_0011);
    tick();

    // Run with idle gaps of 2 and 4 cycles
    pulse_start();
    push_stat("s2_start", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) word(32'h4000_0000 + 32'(i));
    repeat (2) tick();
    for (int i = 4; i < 8; i++) word(32'h4000_0000 + 32'(i));
    repeat (4) tick();
    for (int i = 8; i < 18; i++) word(32'h4000_0000 + 32'(i));
    push_stat("s2_done", 18, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < DEPTH; a++) rd(5'(a), 32'h4000_0000 + 32'(a));
    tick();

    // Idle timeout after 3 results
    pulse_start();
    for (int i = 0; i < 3; i++) word(32'h4100_0000 + 32'(i));
    repeat (TIMEOUT - 1) tick();
    push_stat("s3_pre_timeout", 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    push_stat("s3_timeout", 3, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(5'd3, 32'h4000_0003);
    tick();

    // Restart in the middle of a run
    pulse_start();
    for (int i = 0; i < 7; i++) word(32'h4200_0000 + 32'(i));
    bus.start = 1'b1;
    word(32'h4200_0007);
    bus.start = 1'b0;
    push_stat("s5_restart", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    word(32'h4200_0008);
    push_stat("s5_first", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Same-entry read and write: old word comes back
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h4200_0009;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 5'd1;
    rq.push_back(32'h4200_0001);
    last_rd = 32'h4200_0001;
    tick();
    bus.valid_in = 1'b0;
    bus.rd_en    = 1'b0;
    rd(5'd1, 32'h4200_0009);
    rd(5'd0, 32'h4200_0008);
    rd(5'd7, 32'h4000_0007);
    tick();
    push_stat("s5_count", 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run
    pulse_start();
    for (int i = 0; i < 9; i++) word(32'h4300_0000 + 32'(i));
    resetn = 1'b0;
    word(32'h4300_0009);
    resetn = 1'b1;
    last_rd = 32'h0;
    push_stat("s6_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) word(32'hBAD0_BAD0);
    push_stat("s6_idle_ignore", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(5'd9, 32'h4000_0009);
    rd(5'd0, 32'h4300_0000);
    rd(5'd8, 32'h4300_0008);
    repeat (2) tick();

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_ack; k++) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not acknowledge");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
